// File: rtl/multicore_shared_ram_arbiter.sv
// Round-robin arbiter sharing one single-port 1-cycle-latency RAM between NUM_MASTERS Avalon-MM data masters.
// Latency: grant is combinational in the request cycle; the read response is returned exactly one cycle after acceptance.
// Backpressure: m_waitrequest stalls every master that is not granted this cycle; reset_req stalls all masters and gates ram_clken.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   reset_req           quiesce request: no new grants, RAM clock-enable dropped
//   m_*                 per-master Avalon-MM slave side (packed, master i at slice i)
//   m_readdata          shared read bus, qualified by the one-hot m_readdatavalid
//   ram_*               single-port RAM s1 interface
module multicore_shared_ram_arbiter #(
    parameter int NUM_MASTERS = 8,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                reset_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0]       m_address,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0]   m_byteenable,
    input  logic [NUM_MASTERS-1:0]              m_read,
    input  logic [NUM_MASTERS-1:0]              m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0]       m_writedata,
    output logic [NUM_MASTERS-1:0]              m_waitrequest,
    output logic [NUM_MASTERS-1:0]              m_readdatavalid,
    output logic [DATA_W-1:0]                   m_readdata,
    output logic [ADDR_W-1:0]                   ram_address,
    output logic [DATA_W/8-1:0]                 ram_byteenable,
    output logic                                ram_chipselect,
    output logic                                ram_write,
    output logic [DATA_W-1:0]                   ram_writedata,
    output logic                                ram_clken,
    input  logic [DATA_W-1:0]                   ram_readdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(NUM_MASTERS);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       rr_ptr;
    logic                   rd_vld;
    logic [IDX_W-1:0]       rd_own;

    logic [NUM_MASTERS-1:0] req;
    logic                   any_req;
    logic [IDX_W-1:0]       sel_idx;
    logic                   run_ok;
    logic                   grant_vld;
    logic                   sel_read;
    logic                   sel_write;
    logic                   accept_read;
    int                     cand;

    assign req = m_read | m_write;

    // Grants are blocked while reset is asserted as well, so masters see
    // waitrequest=1 and the RAM sees no chipselect during reset.
    assign run_ok = (state == ST_RUN) && !reset_req && reset_n;

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    // Scanning offsets from the highest down leaves the smallest offset
    // (the closest requester to rr_ptr) as the final assignment.
    always_comb begin
        any_req = 1'b0;
        sel_idx = '0;
        cand    = 0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (req[cand]) begin
                any_req = 1'b1;
                sel_idx = IDX_W'(cand);
            end
        end
    end

    assign grant_vld = any_req && run_ok;
    assign sel_read  = m_read[sel_idx];
    assign sel_write = m_write[sel_idx];

    // Read together with write on one master is a write only; no response.
    assign accept_read = grant_vld && sel_read && !sel_write;

    // Per-master handshake and response steering
    always_comb begin
        m_waitrequest   = '1;
        m_readdatavalid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_waitrequest[i]   = !(grant_vld && (sel_idx == IDX_W'(i)));
            m_readdatavalid[i] = rd_vld && (rd_own == IDX_W'(i));
        end
    end

    // RAM returns data one cycle after the read; pass straight through.
    assign m_readdata = ram_readdata;

    // RAM drive from the granted master; quiet bus otherwise
    always_comb begin
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        if (grant_vld) begin
            ram_chipselect = 1'b1;
            ram_write      = sel_write;
            ram_address    = m_address[sel_idx*ADDR_W +: ADDR_W];
            ram_byteenable = m_byteenable[sel_idx*BE_W +: BE_W];
            ram_writedata  = m_writedata[sel_idx*DATA_W +: DATA_W];
        end
    end

    // The clock enable stays up for the data cycle of a read accepted just
    // before quiescing, so that read still completes.
    assign ram_clken = run_ok || rd_vld;

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (reset_req)  state_nxt = ST_HOLD;
            ST_HOLD: if (!reset_req) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    // Round-robin pointer and one-deep read-response pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            rd_vld <= 1'b0;
            rd_own <= '0;
        end else begin
            rd_vld <= accept_read;
            if (accept_read) begin
                rd_own <= sel_idx;
            end
            if (grant_vld) begin
                if (sel_idx == IDX_W'(NUM_MASTERS - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= sel_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multicore_shared_ram_arbiter.sv
// Bench for multicore_shared_ram_arbiter with a behavioural RAM and a reference model.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: stimulus holds each master's request until the reference model sees it accepted.
module tb_multicore_shared_ram_arbiter;

    localparam int N     = 8;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              reset_req;
    logic [N*AW-1:0]   m_address;
    logic [N*BW-1:0]   m_byteenable;
    logic [N-1:0]      m_read;
    logic [N-1:0]      m_write;
    logic [N*DW-1:0]   m_writedata;
    logic [N-1:0]      m_waitrequest;
    logic [N-1:0]      m_readdatavalid;
    logic [DW-1:0]     m_readdata;
    logic [AW-1:0]     ram_address;
    logic [BW-1:0]     ram_byteenable;
    logic              ram_chipselect;
    logic              ram_write;
    logic [DW-1:0]     ram_writedata;
    logic              ram_clken;
    logic [DW-1:0]     ram_readdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicore_shared_ram_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .reset_req       (reset_req),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_waitrequest   (m_waitrequest),
        .m_readdatavalid (m_readdatavalid),
        .m_readdata      (m_readdata),
        .ram_address     (ram_address),
        .ram_byteenable  (ram_byteenable),
        .ram_chipselect  (ram_chipselect),
        .ram_write       (ram_write),
        .ram_writedata   (ram_writedata),
        .ram_clken       (ram_clken),
        .ram_readdata    (ram_readdata)
    );

    function automatic logic [31:0] pat(int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Behavioural single-port RAM: byte-enabled write, 1-cycle read, clken-gated
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_q = '0;
    bit            ram_init_done = 1'b0;

    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= pat(i);
            ram_init_done <= 1'b1;
        end else if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < BW; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_q <= ram_mem[ram_address];
            end
        end
    end
    assign ram_readdata = ram_q;

    // Reference model: pointer, pending response, quiesce flag, golden memory
    logic [DW-1:0] gold [DEPTH];
    int            mptr;
    bit            mpend;
    int            mown;
    logic [DW-1:0] mdata;
    bit            mhold;

    int            exp_g;
    logic [N-1:0]  exp_wait;
    logic [N-1:0]  exp_rdv;
    logic          exp_cs;
    logic          exp_we;
    logic          exp_clken;
    logic [AW-1:0] exp_addr;
    logic [BW-1:0] exp_be;
    logic [DW-1:0] exp_wd;

    task automatic model_reset();
        mptr  = 0;
        mpend = 0;
        mown  = 0;
        mhold = 0;
    endtask

    task automatic model_eval();
        bit ok;
        ok    = reset_n && !mhold && !reset_req;
        exp_g = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (mptr + k) % N;
            if (exp_g < 0 && (m_read[c] || m_write[c])) exp_g = c;
        end
        if (!ok) exp_g = -1;
        exp_wait = '1;
        exp_rdv  = '0;
        exp_cs   = 1'b0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_be   = '0;
        exp_wd   = '0;
        if (exp_g >= 0) begin
            exp_wait[exp_g] = 1'b0;
            exp_cs   = 1'b1;
            exp_we   = m_write[exp_g];
            exp_addr = m_address[exp_g*AW +: AW];
            exp_be   = m_byteenable[exp_g*BW +: BW];
            exp_wd   = m_writedata[exp_g*DW +: DW];
        end
        if (mpend) exp_rdv[mown] = 1'b1;
        exp_clken = ok || mpend;
    endtask

    task automatic model_commit();
        if (!reset_n) begin
            model_reset();
            return;
        end
        mpend = 0;
        if (exp_g >= 0) begin
            if (exp_we) begin
                for (int b = 0; b < BW; b++)
                    if (exp_be[b]) gold[exp_addr][8*b +: 8] = exp_wd[8*b +: 8];
            end else begin
                mpend = 1;
                mown  = exp_g;
                mdata = gold[exp_addr];
            end
            mptr = (exp_g + 1) % N;
        end
        mhold = reset_req;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic set_req(int i, bit r, bit w, logic [AW-1:0] a, logic [BW-1:0] be, logic [DW-1:0] d);
        m_read[i]                = r;
        m_write[i]               = w;
        m_address[i*AW +: AW]    = a;
        m_byteenable[i*BW +: BW] = be;
        m_writedata[i*DW +: DW]  = d;
    endtask

    task automatic clear_all();
        m_read       = '0;
        m_write      = '0;
        m_address    = '0;
        m_byteenable = '0;
        m_writedata  = '0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        reset_req = 1'b0;
        clear_all();
        model_reset();
        advance();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'($urandom_range(0, DEPTH-1)), '1, '0);
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++; if (m_waitrequest !== 8'hFF) begin errors++; $display("FAIL reset_wait: got %h want ff", m_waitrequest); end
            checks++; if (m_readdatavalid !== 8'h00) begin errors++; $display("FAIL reset_rdv: got %h want 00", m_readdatavalid); end
            checks++; if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", ram_chipselect); end
            advance();
        end
        reset_n = 1'b1;
        settle();
        checks++; if (m_waitrequest !== 8'hFE) begin errors++; $display("FAIL reset_first_grant: got %h want fe", m_waitrequest); end
        advance();
        clear_all();
        settle();
        checks++; if (m_readdatavalid !== exp_rdv) begin errors++; $display("FAIL reset_first_rdv: got %h want %h", m_readdatavalid, exp_rdv); end
        checks++; if (m_readdata !== mdata) begin errors++; $display("FAIL reset_first_data: got %h want %h", m_readdata, mdata); end
        advance();
    endtask

    task automatic test_rr_three();
        int order [3] = '{0, 3, 5};
        int got;
        do_reset();
        foreach (order[j]) set_req(order[j], 1, 0, AW'($urandom_range(0, DEPTH-1)), '1, '0);
        for (int c = 0; c < 12; c++) begin
            settle();
            got = -1;
            for (int i = 0; i < N; i++) if (m_waitrequest[i] === 1'b0) got = i;
            checks++; if (got !== order[c % 3]) begin errors++; $display("FAIL rr3_grant c%0d: got %0d want %0d", c, got, order[c % 3]); end
            checks++; if (ram_address !== exp_addr) begin errors++; $display("FAIL rr3_addr: got %h want %h", ram_address, exp_addr); end
            checks++; if (m_readdatavalid !== exp_rdv) begin errors++; $display("FAIL rr3_rdv: got %h want %h", m_readdatavalid, exp_rdv); end
            if (mpend) begin
                checks++; if (m_readdata !== mdata) begin errors++; $display("FAIL rr3_data: got %h want %h", m_readdata, mdata); end
            end
            advance();
            if (exp_g >= 0) m_address[exp_g*AW +: AW] = AW'($urandom_range(0, DEPTH-1));
        end
        clear_all();
        settle();
        advance();
    endtask

    task automatic test_byte_write();
        logic [31:0] prior;
        logic [31:0] want;
        prior = pat(10'h155);
        want  = {prior[31:16], 16'hBEEF};
        set_req(2, 0, 1, 10'h155, 4'b0011, 32'hDEADBEEF);
        settle();
        checks++; if (m_waitrequest[2] !== 1'b0) begin errors++; $display("FAIL bw_wait2: got %b want 0", m_waitrequest[2]); end
        checks++; if ({ram_write, ram_address, ram_byteenable, ram_writedata} !== {1'b1, 10'h155, 4'b0011, 32'hDEADBEEF}) begin
            errors++; $display("FAIL bw_ram_drive: got we=%b a=%h be=%b d=%h", ram_write, ram_address, ram_byteenable, ram_writedata);
        end
        advance();
        clear_all();
        set_req(6, 1, 0, 10'h155, 4'hF, '0);
        settle();
        checks++; if (m_waitrequest[6] !== 1'b0) begin errors++; $display("FAIL bw_wait6: got %b want 0", m_waitrequest[6]); end
        advance();
        clear_all();
        settle();
        checks++; if (m_readdatavalid !== 8'h40) begin errors++; $display("FAIL bw_rdv: got %h want 40", m_readdatavalid); end
        checks++; if (m_readdata !== want) begin errors++; $display("FAIL bw_data: got %h want %h", m_readdata, want); end
        advance();
    endtask

    task automatic test_all_masters();
        int acc_cyc [N];
        int got;
        do_reset();
        for (int i = 0; i < N; i++) begin
            acc_cyc[i] = -1;
            set_req(i, 1, 0, AW'($urandom_range(0, DEPTH-1)), '1, '0);
        end
        for (int c = 0; c < 10; c++) begin
            settle();
            checks++; if ($countones(~m_waitrequest) > 1) begin errors++; $display("FAIL all_onehot: got %h", m_waitrequest); end
            checks++; if (m_readdatavalid !== exp_rdv) begin errors++; $display("FAIL all_rdv: got %h want %h", m_readdatavalid, exp_rdv); end
            got = -1;
            for (int i = 0; i < N; i++) if (m_waitrequest[i] === 1'b0) got = i;
            if (got >= 0) acc_cyc[got] = (acc_cyc[got] < 0) ? c : 99;
            advance();
            if (exp_g >= 0) set_req(exp_g, 0, 0, '0, '0, '0);
        end
        for (int i = 0; i < N; i++) begin
            checks++; if (acc_cyc[i] !== i) begin errors++; $display("FAIL all_accept m%0d: got cycle %0d want %0d", i, acc_cyc[i], i); end
        end
        clear_all();
    endtask

    task automatic test_reset_req();
        int got;
        do_reset();
        set_req(1, 1, 0, AW'($urandom_range(0, DEPTH-1)), '1, '0);
        settle();
        checks++; if (m_waitrequest !== 8'hFD) begin errors++; $display("FAIL rq_m1_grant: got %h want fd", m_waitrequest); end
        advance();
        reset_req = 1'b1;
        clear_all();
        set_req(0, 1, 0, 10'h001, '1, '0);
        set_req(2, 1, 0, 10'h002, '1, '0);
        set_req(7, 1, 0, 10'h007, '1, '0);
        settle();
        checks++; if (m_readdatavalid !== 8'h02) begin errors++; $display("FAIL rq_m1_rdv: got %h want 02", m_readdatavalid); end
        checks++; if (m_readdata !== mdata) begin errors++; $display("FAIL rq_m1_data: got %h want %h", m_readdata, mdata); end
        checks++; if ({m_waitrequest, ram_chipselect, ram_clken} !== {8'hFF, 1'b0, 1'b1}) begin
            errors++; $display("FAIL rq_first: got wait=%h cs=%b clken=%b want ff 0 1", m_waitrequest, ram_chipselect, ram_clken);
        end
        advance();
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++; if ({m_waitrequest, m_readdatavalid, ram_chipselect, ram_clken} !== {8'hFF, 8'h00, 1'b0, 1'b0}) begin
                errors++; $display("FAIL rq_hold c%0d: got wait=%h rdv=%h cs=%b clken=%b", c, m_waitrequest, m_readdatavalid, ram_chipselect, ram_clken);
            end
            advance();
        end
        reset_req = 1'b0;
        settle();
        checks++; if ({m_waitrequest, ram_clken} !== {8'hFF, 1'b0}) begin
            errors++; $display("FAIL rq_release: got wait=%h clken=%b want ff 0", m_waitrequest, ram_clken);
        end
        advance();
        settle();
        got = -1;
        for (int i = 0; i < N; i++) if (m_waitrequest[i] === 1'b0) got = i;
        checks++; if (got !== 2) begin errors++; $display("FAIL rq_resume: got %0d want 2", got); end
        checks++; if (ram_clken !== 1'b1) begin errors++; $display("FAIL rq_resume_clken: got %b want 1", ram_clken); end
        advance();
        clear_all();
        settle();
        advance();
    endtask

    task automatic test_rw_collision();
        logic [31:0] wd;
        wd = $urandom;
        set_req(4, 1, 1, 10'h010, 4'hF, wd);
        settle();
        checks++; if ({m_waitrequest[4], ram_write, ram_address} !== {1'b0, 1'b1, 10'h010}) begin
            errors++; $display("FAIL rw_accept: got wait=%b we=%b a=%h", m_waitrequest[4], ram_write, ram_address);
        end
        advance();
        clear_all();
        set_req(5, 1, 0, 10'h010, 4'hF, '0);
        settle();
        checks++; if (m_readdatavalid !== 8'h00) begin errors++; $display("FAIL rw_no_rdv: got %h want 00", m_readdatavalid); end
        advance();
        clear_all();
        settle();
        checks++; if (m_readdatavalid !== 8'h20) begin errors++; $display("FAIL rw_m5_rdv: got %h want 20", m_readdatavalid); end
        checks++; if (m_readdata !== wd) begin errors++; $display("FAIL rw_m5_data: got %h want %h", m_readdata, wd); end
        advance();
        set_req(3, 1, 0, 10'h020, 4'hF, '0);
        settle();
        advance();
        clear_all();
        reset_n = 1'b0;
        model_reset();
        settle();
        checks++; if (m_readdatavalid !== 8'h00) begin errors++; $display("FAIL rst_flight: got %h want 00", m_readdatavalid); end
        advance();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++; if (m_readdatavalid !== 8'h00) begin errors++; $display("FAIL rst_stray c%0d: got %h want 00", c, m_readdatavalid); end
            advance();
        end
    endtask

    task automatic test_random();
        int rq_left = 0;
        int kind;
        for (int c = 0; c < 600; c++) begin
            if (rq_left > 0) begin
                rq_left--;
                reset_req = 1'b1;
            end else if ($urandom_range(0, 24) == 0) begin
                rq_left   = $urandom_range(1, 4);
                reset_req = 1'b1;
            end else begin
                reset_req = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (!m_read[i] && !m_write[i] && $urandom_range(0, 1) == 1) begin
                    kind = $urandom_range(0, 9);
                    set_req(i, kind != 6 && kind != 7 && kind != 8 || kind == 9,
                            kind >= 6, AW'($urandom_range(0, 31)), BW'($urandom_range(1, 15)), $urandom);
                end
            end
            settle();
            checks++; if (m_waitrequest !== exp_wait) begin errors++; $display("FAIL rnd_wait c%0d: got %h want %h", c, m_waitrequest, exp_wait); end
            checks++; if (m_readdatavalid !== exp_rdv) begin errors++; $display("FAIL rnd_rdv c%0d: got %h want %h", c, m_readdatavalid, exp_rdv); end
            checks++; if ({ram_chipselect, ram_write, ram_clken} !== {exp_cs, exp_we, exp_clken}) begin
                errors++; $display("FAIL rnd_ctl c%0d: got cs/we/ce=%b%b%b want %b%b%b", c, ram_chipselect, ram_write, ram_clken, exp_cs, exp_we, exp_clken);
            end
            checks++; if ({ram_address, ram_byteenable, ram_writedata} !== {exp_addr, exp_be, exp_wd}) begin
                errors++; $display("FAIL rnd_bus c%0d: got %h %h %h want %h %h %h", c, ram_address, ram_byteenable, ram_writedata, exp_addr, exp_be, exp_wd);
            end
            if (mpend) begin
                checks++; if (m_readdata !== mdata) begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", c, m_readdata, mdata); end
            end
            advance();
            if (exp_g >= 0) set_req(exp_g, 0, 0, '0, '0, '0);
        end
        reset_req = 1'b0;
        clear_all();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) gold[i] = pat(i);
        reset_n   = 1'b0;
        reset_req = 1'b0;
        clear_all();
        model_reset();
        @(negedge clk);
        test_reset();
        test_rr_three();
        test_byte_write();
        test_all_masters();
        test_reset_req();
        test_rw_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
